// File: rtl/wave_dds_pkg.sv
// Shared mode encodings and waveform helpers for the wave_dds_gen DDS waveform generator.
package wave_dds_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SINE   = 2'd3
  } mode_e;

  localparam int unsigned TRI_FOLD_MAX_W = 32;

  // Triangle fold of a w-bit phase: doubles the rising half, inverts the doubled falling half.
  function automatic logic [TRI_FOLD_MAX_W-1:0] tri_fold(input logic [TRI_FOLD_MAX_W-1:0] p,
                                                         input int unsigned w);
    logic [TRI_FOLD_MAX_W-1:0] mask;
    logic [TRI_FOLD_MAX_W-1:0] dbl;
    mask = (32'h0000_0001 << w) - 32'h0000_0001;
    dbl  = (p << 1) & mask;
    return p[w-1] ? (~dbl & mask) : dbl;
  endfunction

endpackage

// File: rtl/wave_sine_lut.sv
// Quarter-wave sine ROM with mirror/invert logic, offset-binary output.
// Only compiled when WAVE_DDS_SINE_EN is defined.
`ifdef WAVE_DDS_SINE_EN
module wave_sine_lut
  import wave_dds_pkg::*;
#(
  parameter int DAC_W = 8
) (
  input  logic [DAC_W-1:0] phase_i,
  output logic [DAC_W-1:0] sample_o
);
  localparam int Q   = 2 ** (DAC_W - 2);
  localparam int AMP = 2 ** (DAC_W - 1) - 1;
  localparam logic [DAC_W-1:0] MID   = {1'b1, {(DAC_W-1){1'b0}}};
  localparam logic [DAC_W-1:0] AMP_V = {1'b0, {(DAC_W-1){1'b1}}};

  function automatic logic [DAC_W-2:0] rom_entry(input int i);
    real x;
    x = real'(AMP) * $sin(3.14159265358979 * real'(i) / real'(2 * Q));
    return (DAC_W-1)'($rtoi(x + 0.5));
  endfunction

  logic [DAC_W-2:0] rom_s [Q];
  logic [1:0]       quad_s;
  logic [DAC_W-3:0] idx_s;
  logic [DAC_W-3:0] idx_mirror_s;
  logic [DAC_W-1:0] mag_s;

  for (genvar gi = 0; gi < Q; gi++) begin : g_rom
    localparam logic [DAC_W-2:0] ENTRY = rom_entry(gi);
    assign rom_s[gi] = ENTRY;
  end

  assign quad_s       = phase_i[DAC_W-1 -: 2];
  assign idx_s        = phase_i[DAC_W-3:0];
  assign idx_mirror_s = ~idx_s + {{(DAC_W-3){1'b0}}, 1'b1};

  // Second/fourth quadrants read the table backwards; their index 0 is the +/- peak.
  always_comb begin
    mag_s = {DAC_W{1'b0}};
    if (!quad_s[0]) begin
      mag_s = {1'b0, rom_s[idx_s]};
    end else if (idx_s == {(DAC_W-2){1'b0}}) begin
      mag_s = quad_s[1] ? MID : AMP_V;
    end else begin
      mag_s = {1'b0, rom_s[idx_mirror_s]};
    end
    if (quad_s[1]) begin
      sample_o = MID - mag_s;
    end else begin
      sample_o = MID + mag_s;
    end
  end

endmodule
`endif

// File: rtl/wave_dds_gen.sv
// Multi-mode DDS waveform generator (square/saw/triangle, sine when WAVE_DDS_SINE_EN is defined).
// Configuration is double-buffered and only takes effect at a period wrap or while en is low.
module wave_dds_gen
  import wave_dds_pkg::*;
#(
  parameter int DAC_W   = 8,
  parameter int PHASE_W = 16,
  parameter int DUTY_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [DUTY_W-1:0]  duty,
  output logic [DAC_W-1:0]   dac_out,
  output logic               wrap_pulse
);

  typedef struct packed {
    mode_e              mode;
    logic [PHASE_W-1:0] freq_word;
    logic [DUTY_W-1:0]  duty;
  } cfg_t;

  localparam logic [DAC_W-1:0] MIDSCALE = {1'b1, {(DAC_W-1){1'b0}}};
  localparam cfg_t CFG_RESET = '{mode:      MODE_SQUARE,
                                 freq_word: {PHASE_W{1'b0}},
                                 duty:      {1'b1, {(DUTY_W-1){1'b0}}}};

  cfg_t               shadow_q, shadow_d;
  cfg_t               active_q, active_d;
  logic               pend_q, pend_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [DAC_W-1:0]   dac_q, dac_d;
  logic               wrap_q, wrap_d;
  logic [PHASE_W:0]   sum_s;
  logic [DAC_W-1:0]   p_s;
  logic [DUTY_W-1:0]  d_s;
  logic [DAC_W-1:0]   wave_s;
  logic [DAC_W-1:0]   sine_s;

  assign p_s = acc_q[PHASE_W-1 -: DAC_W];
  assign d_s = acc_q[PHASE_W-1 -: DUTY_W];

`ifdef WAVE_DDS_SINE_EN
  wave_sine_lut #(.DAC_W(DAC_W)) u_sine (
    .phase_i  (p_s),
    .sample_o (sine_s)
  );
`else
  assign sine_s = MIDSCALE;
`endif

  // Mode mux: turns the current phase into a sample under the active configuration.
  always_comb begin
    wave_s = {DAC_W{1'b0}};
    case (active_q.mode)
      MODE_SQUARE: begin
        if (d_s < active_q.duty) begin
          wave_s = {DAC_W{1'b1}};
        end else begin
          wave_s = {DAC_W{1'b0}};
        end
      end
      MODE_SAW:  wave_s = p_s;
      MODE_TRI:  wave_s = DAC_W'(tri_fold(32'(p_s), DAC_W));
      MODE_SINE: wave_s = sine_s;
      default:   wave_s = {DAC_W{1'b0}};
    endcase
  end

  // Next state: accumulator, delayed wrap flag, output sample and config double-buffer.
  always_comb begin
    sum_s    = {1'b0, acc_q} + {1'b0, active_q.freq_word};
    acc_d    = acc_q;
    carry_d  = carry_q;
    dac_d    = dac_q;
    wrap_d   = 1'b0;
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    if (en) begin
      acc_d   = sum_s[PHASE_W-1:0];
      carry_d = sum_s[PHASE_W];
      dac_d   = wave_s;
      wrap_d  = carry_q;
    end else begin
      wrap_d  = 1'b0;
    end
    // A wrap swaps in the old shadow before a same-cycle load overwrites it.
    if (pend_q && (!en || sum_s[PHASE_W])) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end else begin
      active_d = active_q;
    end
    if (cfg_load) begin
      shadow_d = '{mode: mode_e'(mode), freq_word: freq_word, duty: duty};
      pend_d   = 1'b1;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // State registers with asynchronous reset to the default configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= CFG_RESET;
      active_q <= CFG_RESET;
      pend_q   <= 1'b0;
      acc_q    <= {PHASE_W{1'b0}};
      carry_q  <= 1'b0;
      dac_q    <= {DAC_W{1'b0}};
      wrap_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      dac_q    <= dac_d;
      wrap_q   <= wrap_d;
    end
  end

  assign dac_out    = dac_q;
  assign wrap_pulse = wrap_q;

endmodule
